// File: rtl/vs_logger_pkg.sv
// Shared types and default sizes for the result logger and its FIFO.
package vs_logger_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_TS_W   = 16;
  localparam int DEF_DEPTH  = 8;

  // Record field widths for the default configuration.
  localparam int REC_DATA_W = DEF_DATA_W;
  localparam int REC_TS_W   = DEF_TS_W;
  localparam int REC_W      = REC_DATA_W + REC_TS_W;

  // Capture FSM: IDLE until the source shows a valid sample, RUN while valid.
  typedef enum logic [0:0] {
    LOG_IDLE = 1'b0,
    LOG_RUN  = 1'b1
  } log_state_t;

  // One logged record: value in the upper bits, timestamp in the lower bits.
  typedef struct packed {
    logic [REC_DATA_W-1:0] data;
    logic [REC_TS_W-1:0]   ts;
  } log_rec_t;

  // Pack a value/timestamp pair in the same layout the FIFO stores.
  function automatic log_rec_t make_rec(input logic [REC_DATA_W-1:0] data,
                                        input logic [REC_TS_W-1:0]   ts);
    log_rec_t r;
    r.data = data;
    r.ts   = ts;
    return r;
  endfunction

endpackage

// File: rtl/vs_sync_fifo.sv
// First-word fall-through synchronous FIFO with flush.
// Handshake: a push is taken when push=1 and the FIFO is not full, or when it
// is full and a pop happens in the same cycle; a pop is taken when pop=1 and
// the FIFO is not empty. The head word is visible on rdata while !empty.
module vs_sync_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Pop only from a non-empty FIFO; a full FIFO may push if it pops too.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // Pointers and occupancy; clear overrides any same-cycle push or pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because rdata is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

  // Head word, forced to zero while empty so reset shows a clean output.
  always_comb begin
    rdata = '0;
    if (!empty) rdata = mem[rd_ptr];
  end

endmodule

// File: rtl/vs_result_logger.sv
// Watches a generated FSM's result bus, timestamps each new value and queues
// the records for a debug consumer.
// Consumer handshake: a record is transferred on any cycle where
// out_valid && out_ready; out_valid stays high and out_data/out_ts stay
// stable until that happens.
module vs_result_logger
  import vs_logger_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TS_W        = DEF_TS_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int CAPTURE_ALL = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [TS_W-1:0]         out_ts,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output log_state_t              state
);

  localparam int REC_LW = DATA_W + TS_W;

  log_state_t        state_next;
  logic [TS_W-1:0]   ts;
  logic [DATA_W-1:0] last_data;
  logic              push_req;
  logic              pop;
  logic              full;
  logic              empty;
  logic [REC_LW-1:0] rec_in;
  logic [REC_LW-1:0] rec_out;

  assign pop       = out_valid && out_ready;
  assign out_valid = !empty;
  assign rec_in    = {in_data, ts};
  assign out_data  = rec_out[REC_LW-1:TS_W];
  assign out_ts    = rec_out[TS_W-1:0];

  // Capture FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOG_IDLE;
    else        state <= state_next;
  end

  // Next state: RUN while the source is valid; clear forces IDLE.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = LOG_IDLE;
    end else begin
      case (state)
        LOG_IDLE: if (in_valid)  state_next = LOG_RUN;
        LOG_RUN:  if (!in_valid) state_next = LOG_IDLE;
        default:  state_next = LOG_IDLE;
      endcase
    end
  end

  // Push decision: first valid sample always logs, later ones only on change
  // unless every valid cycle is being captured.
  always_comb begin
    push_req = 1'b0;
    case (state)
      LOG_IDLE: push_req = in_valid;
      LOG_RUN:  push_req = in_valid && ((CAPTURE_ALL != 0) || (in_data != last_data));
      default:  push_req = 1'b0;
    endcase
  end

  // Free-running timestamp, wraps silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts <= '0;
    else        ts <= ts + TS_W'(1);
  end

  // Change-detect reference follows every valid sample, logged or not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        last_data <= '0;
    else if (in_valid) last_data <= in_data;
  end

  // Sticky overflow: a record was lost because the FIFO was full with no pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           overflow <= 1'b0;
    else if (clear)                       overflow <= 1'b0;
    else if (push_req && full && !pop)    overflow <= 1'b1;
  end

  vs_sync_fifo #(
    .W     (REC_LW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .clear (clear),
    .wdata (rec_in),
    .rdata (rec_out),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule
